// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 3-stage BT.601 full-range RGB -> YCbCr with valid/ready, rounding, clamp, bypass and sideband
module rgb2ycbcr_pipe #(
    parameter int PIX_W  = 8,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_r,
    input  logic [PIX_W-1:0]  in_g,
    input  logic [PIX_W-1:0]  in_b,
    input  logic              in_bypass,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_y,
    output logic [PIX_W-1:0]  out_cb,
    output logic [PIX_W-1:0]  out_cr,
    output logic [USER_W-1:0] out_user
);
    localparam int SW = PIX_W + 10;
    // Coefficient matrix, row-major: Y row, Cb row, Cr row; columns R, G, B.
    localparam int C [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
    localparam logic signed [SW-1:0] ZERO = '0;
    localparam logic signed [SW-1:0] RND  = SW'(128);
    localparam logic signed [SW-1:0] OFS  = SW'(2 ** (PIX_W - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** PIX_W - 1);

    logic                     adv;
    logic                     acc;
    logic                     v1_q, v2_q, v3_q;
    logic                     byp1_q, byp2_q;
    logic [USER_W-1:0]        user1_q, user2_q, user3_q;
    logic [PIX_W-1:0]         px [3];
    logic signed [SW-1:0]     p_d [9];
    logic signed [SW-1:0]     p_q [9];
    logic signed [SW-1:0]     s_d [3];
    logic signed [SW-1:0]     s_q [3];
    logic signed [SW-1:0]     t [3];
    logic [PIX_W-1:0]         o_d [3];
    logic [PIX_W-1:0]         o_q [3];

    function automatic logic signed [SW-1:0] mul(input int c, input logic [PIX_W-1:0] x);
        return SW'(c * int'(x));
    endfunction

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv && !rst;
    assign acc       = in_valid && in_ready;
    assign out_valid = v3_q;
    assign out_y     = o_q[0];
    assign out_cb    = o_q[1];
    assign out_cr    = o_q[2];
    assign out_user  = user3_q;

    // S1 products; bypass puts each channel scaled by 256 on the diagonal so it falls out of the shift untouched
    always_comb begin
        px = '{in_r, in_g, in_b};
        for (int i = 0; i < 9; i++)
            p_d[i] = in_bypass ? ((i / 3 == i % 3) ? mul(256, px[i % 3]) : ZERO) : mul(C[i], px[i % 3]);
    end

    // S2 row sums with the rounding constant folded in
    always_comb begin
        for (int k = 0; k < 3; k++)
            s_d[k] = p_q[3*k] + p_q[3*k+1] + p_q[3*k+2] + RND;
    end

    // S3 floor shift, chroma offset (skipped for bypass) and saturation to the output range
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            t[k]   = (s_q[k] >>> 8) + ((k == 0 || byp2_q) ? ZERO : OFS);
            o_d[k] = (t[k] < ZERO) ? '0 : (t[k] > MAXV) ? MAXV[PIX_W-1:0] : t[k][PIX_W-1:0];
        end
    end

    // Valid chain and output registers; outputs only update when a real pixel reaches the last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            o_q     <= '{default: '0};
            user3_q <= '0;
        end else if (adv) begin
            v1_q <= acc;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                o_q     <= o_d;
                user3_q <= user2_q;
            end
        end
    end

    // Datapath stages load only when they receive a real pixel, so idle input data never toggles them
    always_ff @(posedge clk) begin
        if (acc) begin
            p_q     <= p_d;
            byp1_q  <= in_bypass;
            user1_q <= in_user;
        end
        if (adv && v1_q) begin
            s_q     <= s_d;
            byp2_q  <= byp1_q;
            user2_q <= user1_q;
        end
    end
endmodule
